// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and counter sizing for the sequential multiplier
package mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;
  // Counter holds values 0..width, so it needs clog2(width+1) bits
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
endpackage

// File: rtl/mult_shift_add_core.sv
// mult_shift_add_core: unsigned shift-add datapath (accumulator, single adder, step counter)
//   clk, rst      clock, async active-high reset
//   load          latch mcand/mplier, clear upper accumulator, count=WIDTH
//   step          one add-and-shift iteration, count decrements
//   mcand, mplier unsigned operands sampled on load
//   acc           2*WIDTH accumulator; holds the product once count reaches 0
//   count         remaining iterations
module mult_shift_add_core import mult_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CW = cnt_w(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc,
  output logic [CW-1:0]      count
);
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH:0]   sum;
  // The multiplier lives in the low half of acc and shifts out through acc[0]
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand_q} : '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      count   <= '0;
      mcand_q <= '0;
    end else if (load) begin
      acc     <= {{WIDTH{1'b0}}, mplier};
      count   <= CW'(WIDTH);
      mcand_q <= mcand;
    end else if (step) begin
      acc   <= {sum, acc[WIDTH-1:1]};
      count <= count - 1'b1;
    end
  end
endmodule

// File: rtl/seq_array_multiplier.sv
// seq_array_multiplier: start/done shift-add multiplier, unsigned or two's complement
//   clk, rst     clock, async active-high reset
//   start        request, accepted only while idle
//   signed_mode  1 = operands and product are two's complement
//   A, B         operands, sampled on the accepting edge
//   busy         high from accept until the result is written
//   done         one-cycle pulse when P is written
//   P            product, held until the next result
module seq_array_multiplier import mult_pkg::*; #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);
  localparam int CW = cnt_w(WIDTH);
  state_t             state;
  logic               neg;
  logic               load;
  logic               step;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude
  assign mag_a = (signed_mode && A[WIDTH-1]) ? -A : A;
  assign mag_b = (signed_mode && B[WIDTH-1]) ? -B : B;
  assign load  = (state == IDLE) && start;
  assign step  = (state == CALC);
  mult_shift_add_core #(.WIDTH(WIDTH), .CW(CW)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .mcand  (mag_a),
    .mplier (mag_b),
    .acc    (acc),
    .count  (count)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      P     <= '0;
      neg   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          neg   <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
          busy  <= 1'b1;
          state <= CALC;
        end
        CALC: if (count == CW'(1)) state <= FINISH;
        FINISH: begin
          P     <= neg ? -acc : acc;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/seq_array_multiplier.md
# seq_array_multiplier

Parametrised sequential shift-add multiplier; successor to the team's combinational 8-bit array multiplier. Accepts one operand pair per request via a start/done handshake, computes over WIDTH cycles with a single adder, and supports unsigned and two's-complement modes. Sits wherever area matters more than throughput (MAC front-ends, DSP lab designs) and is a drop-in replacement for the combinational multiplier behind a simple request interface.

## Interface
- WIDTH, 8, operand width in bits (WIDTH >= 2); product width is 2*WIDTH
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only while idle (busy=0)
- signed_mode  input  1  1 = A, B, P two's complement; 0 = unsigned; sampled with start
- A  input  WIDTH  multiplicand; sampled with start
- B  input  WIDTH  multiplier; sampled with start
- busy  output  1  high from the accepting edge until the result is written
- done  output  1  one-cycle pulse, P valid
- P  output  2*WIDTH  product; holds until the next result is written

## Operation
- States: IDLE, CALC, FINISH.
- IDLE: busy=0. When start=1 at a rising edge, latch signed_mode and the operand magnitudes (|A|, |B| when signed_mode=1, raw otherwise). Latch sign flag neg = signed_mode & (A[W-1] ^ B[W-1]). Clear the accumulator, load count=WIDTH, go to CALC.
- CALC: each cycle, if the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator (WIDTH+1-bit add, carry kept). Shift {carry, acc} right by 1. Decrement count; at count==1 go to FINISH.
- FINISH: P <= neg ? -acc : acc (2*WIDTH bits, mod 2^(2W)); done <= 1 for one cycle; go to IDLE.
- Width rules: |−2^(W−1)| = 2^(W−1) fits in WIDTH unsigned bits. Magnitude product ≤ 2^(2W−2) in signed mode and ≤ (2^W−1)^2 unsigned; both fit in 2W bits, so no overflow.
- start while busy=1: ignored, with no queuing. A, B and signed_mode are don't-care except on the accepting edge.
- start in the done cycle: accepted, because state is already IDLE.
- Zero operands need no early-out; latency is constant.
- Reset (any time, including mid-CALC): state=IDLE, busy=0, done=0, P=0, accumulator/count=0. An aborted operation produces no done.

## Timing
- Accept at edge t0. CALC occupies edges t1..tWIDTH. FINISH writes P/done at edge t(WIDTH+1).
- done is high for exactly the cycle after edge t(WIDTH+1). Latency = WIDTH+1 clocks from accept to done.
- busy rises after t0 and falls after t(WIDTH+1), in the same cycle that done rises.
- Back-to-back throughput: one product per WIDTH+2 clocks (WIDTH=8: 10).
- P changes only at FINISH edges and at reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package mult_pkg holds:
  - the state encoding constants (IDLE, CALC, FINISH);
  - a counter-width function, clog2(WIDTH+1).
- One sub-module is natural: mult_shift_add_core, holding the accumulator, add/shift and counter datapath with load/step controls. seq_array_multiplier keeps the FSM, the sign pre/post-processing and the output registers.
- Sign handling stays outside the core, so the core is purely unsigned and reusable.

## Test plan
- Unsigned, WIDTH=8: A=12, B=2, start one cycle → done exactly 9 clocks later, P=24. Also A=255, B=255 → P=0xFE01.
- Signed, WIDTH=8:
  - A=−5 (0xFB), B=6 → P=0xFFE2 (−30).
  - A=−128, B=−128 → P=0x4000.
  - A=−128, B=127 → P=0xC080.
- Handshake: assert start continuously for 30 cycles with A=31, B=3 → done every 10 clocks, P=93 each time. Change A while busy → P unaffected.
- Back-to-back: new start with A=10, B=10 in the done cycle of the previous op → accepted; next done after 9 clocks with P=100. Previous P holds until then.
- Reset mid-CALC: assert rst 4 cycles after accept → P=0, busy=0, done=0 immediately (asynchronously). No done ever follows; a new request after reset completes normally.
- Parametric: WIDTH=16, random signed/unsigned pairs (≥1000) checked against a reference model → all match; latency = 17 clocks.
